// File: rtl/vend_arbiter.sv
// ----------------------------------------------------------------------------
// vend_arbiter -- shares one vending machine between two customer panels.
//
// A panel raises its req to open a session. The arbiter grants one panel
// (round-robin on simultaneous requests), forwards that panel's coin and
// drink selection to the machine (registered, one cycle late), watches the
// machine FSM through dispense and checkout, and reports the drink and the
// change as a one-cycle result strobe.
//
// Optional feature, macro VEND_TIMEOUT_EN: an idle counter aborts an OPEN
// session after TIMEOUT_CYC cycles without coin or selection activity. The
// abort pulses the machine reset for one cycle and completes the session
// through VEND/CLOSE with res_abort=1 and res_drink=0 (change = refund).
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req0/1                       panel session requests
//   i_coin0/1 [7:0]                panel coin values
//   i_choose0/1 [2:0]              panel drink selection
//   i_vm_state [2:0]               machine FSM state (2 dispense, 3 checkout)
//   i_vm_drink_out, i_vm_exchange  machine drink ID and change
//   o_vm_coin, o_vm_drink_choose   registered stimulus to the machine
//   o_vm_rst_n                     active-low reset to the machine
//   o_grant [1:0]                  one-hot session owner, 00 when free
//   o_arb_state [2:0]              arbiter FSM state
//   o_res_valid/id/abort           result strobe, panel served, aborted
//   o_res_drink, o_res_change      dispensed drink ID and change returned
// ----------------------------------------------------------------------------
module vend_arbiter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic [7:0] i_coin0,
    input  logic [7:0] i_coin1,
    input  logic [2:0] i_choose0,
    input  logic [2:0] i_choose1,
    input  logic [2:0] i_vm_state,
    input  logic [7:0] i_vm_drink_out,
    input  logic [7:0] i_vm_exchange,
    output logic [7:0] o_vm_coin,
    output logic [2:0] o_vm_drink_choose,
    output logic       o_vm_rst_n,
    output logic [1:0] o_grant,
    output logic [2:0] o_arb_state,
    output logic       o_res_valid,
    output logic       o_res_id,
    output logic       o_res_abort,
    output logic [7:0] o_res_drink,
    output logic [7:0] o_res_change
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_VEND  = 3'd2,
        S_CLOSE = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t     r_state, w_next;
    logic [1:0] r_grant;
    logic       r_last_served;
    logic [7:0] r_vm_coin;
    logic [2:0] r_vm_choose;
    logic [7:0] r_drink;          // drink captured at checkout, published at CLOSE
    logic       r_res_valid, r_res_id, r_res_abort;
    logic [7:0] r_res_drink, r_res_change;
    logic       w_aborted;
    logic       w_timeout;

    // Granted panel's inputs; the other panel is never looked at.
    logic [7:0] w_coin;
    logic [2:0] w_choose;
    assign w_coin   = r_grant[1] ? i_coin1   : i_coin0;
    assign w_choose = r_grant[1] ? i_choose1 : i_choose0;

    // Panel 1 wins if it asks alone, or if both ask and panel 0 was served last.
    logic w_pick1;
    assign w_pick1 = i_req1 & (~i_req0 | ~r_last_served);

`ifdef VEND_TIMEOUT_EN
    localparam int             CW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_idle_cnt;
    logic          r_abort;
    logic          r_vm_rst_n;
    logic          w_idle;

    assign w_idle    = (r_state == S_OPEN) && (w_coin == 8'd0) && (w_choose == 3'd0);
    assign w_timeout = w_idle && (r_idle_cnt == TO_LAST);
    assign w_aborted = r_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle_cnt <= '0;
            r_abort    <= 1'b0;
            r_vm_rst_n <= 1'b1;
        end else begin
            r_idle_cnt <= (w_idle && w_next == S_OPEN) ? r_idle_cnt + 1'b1 : '0;
            r_vm_rst_n <= (w_next != S_ABORT);
            if (w_next == S_ABORT)
                r_abort <= 1'b1;
            else if (r_state == S_IDLE)
                r_abort <= 1'b0;
        end
    end

    assign o_vm_rst_n = r_vm_rst_n;
`else
    assign w_timeout  = 1'b0;
    assign w_aborted  = 1'b0;
    assign o_vm_rst_n = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = (i_req0 | i_req1) ? S_OPEN : S_IDLE;
            // Dispense takes priority over a timeout landing in the same cycle.
            S_OPEN:  w_next = (i_vm_state == 3'd2) ? S_VEND :
                              w_timeout            ? S_ABORT : S_OPEN;
            S_ABORT: w_next = S_VEND;
            S_VEND:  w_next = (i_vm_state == 3'd3) ? S_CLOSE : S_VEND;
            S_CLOSE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant       <= 2'b00;
            r_last_served <= 1'b1;
            r_vm_coin     <= '0;
            r_vm_choose   <= '0;
            r_drink       <= '0;
            r_res_valid   <= 1'b0;
            r_res_id      <= 1'b0;
            r_res_abort   <= 1'b0;
            r_res_drink   <= '0;
            r_res_change  <= '0;
        end else begin
            r_res_valid <= 1'b0;
            // Machine stimulus is zero everywhere except while staying in OPEN.
            r_vm_coin   <= '0;
            r_vm_choose <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_OPEN)
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
                end
                S_OPEN: begin
                    if (w_next == S_OPEN) begin
                        r_vm_coin   <= w_coin;
                        r_vm_choose <= w_choose;
                    end
                end
                S_VEND: begin
                    if (i_vm_state == 3'd3)
                        r_drink <= w_aborted ? 8'd0 : i_vm_drink_out;
                end
                S_CLOSE: begin
                    // All result fields change together with the strobe.
                    r_res_valid   <= 1'b1;
                    r_res_id      <= r_grant[1];
                    r_res_abort   <= w_aborted;
                    r_res_drink   <= r_drink;
                    r_res_change  <= i_vm_exchange;
                    r_last_served <= r_grant[1];
                    r_grant       <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign o_vm_coin         = r_vm_coin;
    assign o_vm_drink_choose = r_vm_choose;
    assign o_grant           = r_grant;
    assign o_arb_state       = r_state;
    assign o_res_valid       = r_res_valid;
    assign o_res_id          = r_res_id;
    assign o_res_abort       = r_res_abort;
    assign o_res_drink       = r_res_drink;
    assign o_res_change      = r_res_change;

endmodule

// File: doc/vend_arbiter.md
VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
- REQ-001: Parameter TIMEOUT_CYC, default 64, is the number of idle cycles that aborts a session (used only with VEND_TIMEOUT_EN).
- REQ-002: clk  in  1  single clock; all state updates on rising edge.
- REQ-003: reset  in  1  asynchronous, active-low reset.
- REQ-004: req0, req1  in  1 each  panel session requests.
- REQ-005: coin0, coin1  in  8 each  panel coin values (0, 1, 5, 10 or 50).
- REQ-006: choose0, choose1  in  3 each  panel drink selection (0 none, 1 tea, 2 coke, 3 coffee, 4 milk).
- REQ-007: vm_state  in  3  vending machine FSM state (0 accumulate, 1 select, 2 dispense, 3 checkout).
- REQ-008: vm_drink_out, vm_exchange  in  8 each  machine drink ID and change.
- REQ-009: vm_coin  out  8, vm_drink_choose  out  3  registered stimulus to the machine.
- REQ-010: vm_rst_n  out  1  active-low reset to the machine.
- REQ-011: grant  out  2  one-hot owner of the machine; 00 when free.
- REQ-012: arb_state  out  3  arbiter FSM state.
- REQ-013: res_valid  out  1  one-cycle result strobe; res_id  out  1  panel served; res_abort  out  1  session aborted.
- REQ-014: res_drink, res_change  out  8 each  dispensed drink ID and change returned.

Function
- REQ-015: The arbiter FSM SHALL have states IDLE=0, OPEN=1, VEND=2, CLOSE=3 and ABORT=4; any other encoding SHALL go to IDLE.
- REQ-016: In IDLE the block SHALL drive grant=00, vm_coin=0 and vm_drink_choose=0, and SHALL sample req0 and req1 every cycle.
- REQ-017: When exactly one req is high in IDLE, that panel SHALL be granted on the next edge, and the FSM SHALL move to OPEN.
- REQ-018: When both reqs are high in IDLE, the panel not equal to last_served SHALL win; last_served SHALL reset to 1, so panel 0 wins first.
- REQ-019: In OPEN, vm_coin and vm_drink_choose SHALL equal the granted panel's coin and choose delayed by one cycle; the non-granted panel's inputs SHALL be ignored.
- REQ-020: In OPEN, observing vm_state==2 SHALL move the FSM to VEND, and vm_coin and vm_drink_choose SHALL be forced to 0 from then until the next OPEN.
- REQ-021: In VEND, observing vm_state==3 SHALL capture vm_drink_out into res_drink (0 if the session is aborted) and SHALL move the FSM to CLOSE.
- REQ-022: In CLOSE (one cycle), the block SHALL capture vm_exchange into res_change and pulse res_valid with res_id set to the granted panel.
- REQ-023: The same CLOSE cycle SHALL update last_served, clear grant and return the FSM to IDLE.
- REQ-024: res_drink, res_change, res_id and res_abort SHALL hold their values until the next res_valid.
- REQ-025: req deassertion outside IDLE SHALL be ignored; a session ends only through CLOSE.
- REQ-026: Change width SHALL be 8 bits with no saturation; the value is passed through from vm_exchange.
- REQ-027: Minimum latency from req to grant SHALL be 1 cycle; minimum time between consecutive grants SHALL be 1 IDLE cycle.

Reset
- REQ-028: Asserting reset SHALL force IDLE, grant=00, vm_coin=0, vm_drink_choose=0, vm_rst_n=1, res_valid=0, res_abort=0, res_id=0, res_drink=0, res_change=0, the idle counter to 0 and last_served to 1.
- REQ-029: Reset mid-session SHALL abandon the session without a res_valid; vm_rst_n SHALL stay 1.

Configuration
- REQ-030: With VEND_TIMEOUT_EN defined, an idle counter SHALL count OPEN cycles in which the granted coin==0 and choose==0, and SHALL clear on any activity or on leaving OPEN.
- REQ-031: With VEND_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL move the FSM to ABORT.
- REQ-032: ABORT SHALL drive vm_rst_n=0 for exactly one cycle, set res_abort=1 for the session, and move the FSM to VEND; the session then completes through VEND and CLOSE, refunding through vm_exchange.
- REQ-033: Without VEND_TIMEOUT_EN, there SHALL be no counter and no ABORT path, vm_rst_n SHALL be constant 1, and OPEN SHALL wait indefinitely.

Verification
- REQ-034: Release reset -> arb_state=0, grant=00, vm_rst_n=1, res_valid=0, all data outputs 0.
- REQ-035: req0 pulse; coin0=10 for 1 cycle; choose0=1 held -> grant=01 next cycle, vm_coin=10 one cycle later, then res_valid with res_id=0, res_drink=1, res_change=0.
- REQ-036: req0 and req1 high together -> panel 0 served first; coin1=50 during panel 0's session never reaches vm_coin; grant=10 one IDLE cycle after panel 0's res_valid.
- REQ-037: Panel 1 session with coin 50 and choose=2 -> res_id=1, res_drink=2, res_change=35.
- REQ-038: VEND_TIMEOUT_EN, TIMEOUT_CYC=8; coins 5 then 5, then 8 idle cycles -> single-cycle vm_rst_n=0, res_valid with res_abort=1, res_drink=0, res_change=10.
- REQ-039: reset asserted while in OPEN -> immediate IDLE, grant=00, no res_valid.
